// File: rtl/vga_out_pkg.sv
// Shared constants and types for the VGA output stage: pipeline latency,
// 4x4 Bayer threshold matrix and index/threshold typedefs.
package vga_out_pkg;

    localparam int unsigned VGA_OUT_LATENCY = 2;

    typedef logic [1:0] idx_t;
    typedef logic [3:0] thr_t;

    // Row-major: entry {y, x}
    localparam thr_t BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    function automatic thr_t bayer_thr(input idx_t y, input idx_t x);
        return BAYER[{y, x}];
    endfunction

endpackage

// File: rtl/vga_out_stage_dither_q2.sv
// Combinational 8-bit to 2-bit quantiser with optional ordered-dither bump
// that saturates at 3.
module dither_q2
    import vga_out_pkg::*;
(
    input  logic [7:0] v,
    input  thr_t       t,
    input  logic       en,
    output logic [1:0] q
);

    always_comb begin
        q = v[7:6];
        if (en && (v[7:6] != 2'd3) && (v[5:2] > t)) begin
            q = v[7:6] + 2'd1;
        end
    end

endmodule

// File: rtl/vga_out_stage.sv
// Two-stage VGA output pipeline with 2-bit ordered-dither digital outputs.
// Define VGA_OUT_TEMPORAL_DITHER_EN to rotate the Bayer pattern per frame.
module vga_out_stage
    import vga_out_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       hblank_in,
    input  logic       vblank_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic       dither_en,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [1:0] rq,
    output logic [1:0] gq,
    output logic [1:0] bq
);

    idx_t xph, yph, xi, yi;
    logic hb_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            xph     <= '0;
            yph     <= '0;
            hb_prev <= 1'b1;
        end else begin
            xph     <= hblank_in ? 2'd0 : xph + 2'd1;
            hb_prev <= hblank_in;
            if (vblank_in) begin
                yph <= '0;
            end else if (hblank_in && !hb_prev) begin
                yph <= yph + 2'd1;
            end
        end
    end

`ifdef VGA_OUT_TEMPORAL_DITHER_EN
    idx_t fc;
    logic vb_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            fc      <= '0;
            vb_prev <= 1'b1;
        end else begin
            vb_prev <= vblank_in;
            if (vblank_in && !vb_prev) begin
                fc <= fc + 2'd1;
            end
        end
    end

    assign xi = xph ^ {fc[1], fc[0]};
    assign yi = yph ^ {fc[0], fc[1]};
`else
    assign xi = xph;
    assign yi = yph;
`endif

    // Stage 1: raw inputs plus the indices belonging to this pixel
    logic       hs1, vs1, hb1, vb1, den1;
    logic [7:0] r1, g1, b1;
    idx_t       xi1, yi1;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            hb1  <= 1'b0;
            vb1  <= 1'b0;
            den1 <= 1'b0;
            r1   <= '0;
            g1   <= '0;
            b1   <= '0;
            xi1  <= '0;
            yi1  <= '0;
        end else begin
            hs1  <= hsync_in;
            vs1  <= vsync_in;
            hb1  <= hblank_in;
            vb1  <= vblank_in;
            den1 <= dither_en;
            r1   <= r_in;
            g1   <= g_in;
            b1   <= b_in;
            xi1  <= xi;
            yi1  <= yi;
        end
    end

    thr_t       thr;
    logic [1:0] rq_c, gq_c, bq_c;
    logic       blank1;

    assign thr    = bayer_thr(yi1, xi1);
    assign blank1 = hb1 | vb1;

    dither_q2 u_q_r (.v(r1), .t(thr), .en(den1), .q(rq_c));
    dither_q2 u_q_g (.v(g1), .t(thr), .en(den1), .q(gq_c));
    dither_q2 u_q_b (.v(b1), .t(thr), .en(den1), .q(bq_c));

    // Stage 2: gating uses stage-1 blanks, which are the blanks emitted alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync  <= 1'b0;
            vsync  <= 1'b0;
            hblank <= 1'b0;
            vblank <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
            rq     <= '0;
            gq     <= '0;
            bq     <= '0;
        end else begin
            hsync  <= hs1;
            vsync  <= vs1;
            hblank <= hb1;
            vblank <= vb1;
            r      <= blank1 ? 8'd0 : r1;
            g      <= blank1 ? 8'd0 : g1;
            b      <= blank1 ? 8'd0 : b1;
            rq     <= blank1 ? 2'd0 : rq_c;
            gq     <= blank1 ? 2'd0 : gq_c;
            bq     <= blank1 ? 2'd0 : bq_c;
        end
    end

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed self-checking bench for vga_out_stage (default build, no temporal dither).
module tb_vga_out_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in, vsync_in, hblank_in, vblank_in, dither_en;
    logic [7:0] r_in, g_in, b_in;
    logic       hsync, vsync, hblank, vblank;
    logic [7:0] r, g, b;
    logic [1:0] rq, gq, bq;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  pv_ctl = '0;
    logic [23:0] pv_rgb = '0;
    logic [5:0]  pv_q   = '0;

    logic [1:0] pat [4][4] = '{
        '{2'd2, 2'd1, 2'd2, 2'd1},
        '{2'd1, 2'd2, 2'd1, 2'd2},
        '{2'd2, 2'd1, 2'd2, 2'd1},
        '{2'd1, 2'd2, 2'd1, 2'd2}
    };

    vga_out_stage dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .dither_en(dither_en),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .r(r), .g(g), .b(b), .rq(rq), .gq(gq), .bq(bq)
    );

    always #5 clk = ~clk;

    // Outputs seen after an edge belong to the pixel driven one step earlier
    task automatic step(input string tag, input logic rst,
                        input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [7:0] ri, input logic [7:0] gi, input logic [7:0] bi,
                        input logic den,
                        input logic [1:0] erq, input logic [1:0] egq, input logic [1:0] ebq);
        logic blank;
        blank     = hb | vb;
        reset     = rst;
        hsync_in  = hs;
        vsync_in  = vs;
        hblank_in = hb;
        vblank_in = vb;
        r_in      = ri;
        g_in      = gi;
        b_in      = bi;
        dither_en = den;
        @(posedge clk);
        #1;
        if (rst) begin
            pv_ctl = '0;
            pv_rgb = '0;
            pv_q   = '0;
        end
        checks++;
        assert ({hsync, vsync, hblank, vblank} === pv_ctl)
        else begin
            failures++;
            $error("FAIL %s ctl got=%b exp=%b", tag, {hsync, vsync, hblank, vblank}, pv_ctl);
        end
        checks++;
        assert ({r, g, b} === pv_rgb)
        else begin
            failures++;
            $error("FAIL %s rgb got=%h exp=%h", tag, {r, g, b}, pv_rgb);
        end
        checks++;
        assert ({rq, gq, bq} === pv_q)
        else begin
            failures++;
            $error("FAIL %s q got=%b exp=%b", tag, {rq, gq, bq}, pv_q);
        end
        if (!rst) begin
            pv_ctl = {hs, vs, hb, vb};
            pv_rgb = blank ? 24'd0 : {ri, gi, bi};
            pv_q   = blank ? 6'd0 : {erq, egq, ebq};
        end
    endtask

    initial begin
        reset = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0; dither_en = 1'b0;

        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);

        step("vblank",   1'b0, 1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
        step("vbl_end",  1'b0, 0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);

        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++)
                step("bayer", 1'b0, 0, 0, 0, 0, 8'h60, 8'hFF, 8'h00, 1, pat[y][x], 2'd3, 2'd0);
            step("row_hbl", 1'b0, 0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
        end

        step("trunc",    1'b0, 0, 0, 0, 0, 8'hBF, 8'h40, 8'h80, 0, 2'd2, 2'd1, 2'd2);
        step("latency",  1'b0, 1, 0, 0, 0, 8'h5A, 8'h00, 8'h00, 0, 2'd1, 2'd0, 2'd0);
        step("den_on",   1'b0, 0, 0, 0, 0, 8'h60, 8'h00, 8'h00, 1, 2'd2, 2'd0, 2'd0);
        step("den_off",  1'b0, 0, 0, 0, 0, 8'h7C, 8'h00, 8'h00, 0, 2'd1, 2'd0, 2'd0);
        step("hbl_gate", 1'b0, 0, 0, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
        step("xph_rst",  1'b0, 0, 0, 0, 0, 8'h60, 8'h7C, 8'hFF, 1, 2'd1, 2'd2, 2'd3);
        step("vbl_gate", 1'b0, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
        step("rst_mid",  1'b1, 1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 0);
        step("drain",    1'b0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        step("drain2",   1'b0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_out_stage.md
# vga_out_stage

Output stage directly downstream of the pattern controller. It registers the controller's 24-bit RGB, sync and blanking signals through a fixed 2-cycle pipeline, forwarding them to the DAC pins. It also derives 2-bit-per-channel digital outputs from the 8-bit channels using 4x4 ordered (Bayer) dithering. All outputs leave the block time-aligned.

## Interface
Parameters:
- none; latency and Bayer matrix are package constants.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hsync_in  in  1  from controller; polarity passed through untouched
- vsync_in  in  1  from controller; polarity passed through untouched
- hblank_in  in  1  high during horizontal blanking
- vblank_in  in  1  high during vertical blanking
- r_in, g_in, b_in  in  8 each  controller colour
- dither_en  in  1  1 = ordered dither on digital outs, 0 = plain truncation; sampled every cycle
- hsync, vsync  out  1 each  delayed syncs
- hblank, vblank  out  1 each  delayed blanks
- r, g, b  out  8 each  delayed DAC colour; forced 0 when delayed blank is high
- rq, gq, bq  out  2 each  digital colour; forced 0 when blanked

## Operation
Position trackers are updated from stage-1 inputs:
- xph (2b): 0 while hblank_in; else +1 per cycle, wrapping 3→0.
- yph (2b): 0 while vblank_in; else +1 on each hblank_in rising edge (hblank_in & ~hb_prev).
- fc (2b, frame count): +1 on each vblank_in rising edge; wraps.
- hb_prev and vb_prev are registered copies of the blanks.
- Edge cases:
  - If vblank and hblank rise together, the yph clear wins.
  - The indices applied to a pixel are the tracker values in the cycle that pixel is present at the inputs. The first visible pixel of the first visible line therefore uses (x,y) = (0,0).

Quantiser, applied per channel to the 8-bit value v with threshold T = B[yi][xi]:
- dither_en = 0: q = v[7:6].
- dither_en = 1: q = (v[7:6] == 3) ? 3 : v[7:6] + (v[5:2] > T). Result saturates at 3 and never wraps.
- Bayer matrix B, rows y = 0..3 (columns x = 0..3):
  - y0: 0 8 2 10
  - y1: 12 4 14 6
  - y2: 3 11 1 9
  - y3: 15 7 13 5
- Without temporal dither, xi = xph and yi = yph.

Blanking:
- The stage-2 outputs r/g/b and rq/gq/bq are 0 whenever the delayed hblank or vblank is 1.
- Sync and blank outputs are never gated.

## Timing
- Latency is exactly 2 cycles, input to output, for every output.
- Stage 1 registers the inputs, dither_en and the computed (xi, yi).
- Stage 2 registers the quantised and gated results.
- dither_en is pipelined with its pixel, so a change affects exactly the pixel presented in that cycle.
- While reset is asserted:
  - all pipeline registers are 0, so all outputs are 0, including hsync and vsync;
  - xph, yph and fc are 0;
  - hb_prev and vb_prev are 1, so the first cycle after reset produces no spurious edge.
- Reset mid-frame: outputs are 0 on the cycle after reset is sampled. Trackers restart and resynchronise at the next hblank/vblank.
- No handshake: the block accepts one pixel per clock and never stalls.

## Configuration
- Macro: VGA_OUT_TEMPORAL_DITHER_EN.
- Defined: xi = xph ^ {fc[1], fc[0]} and yi = yph ^ {fc[0], fc[1]}. The pattern shifts every frame and repeats every 4 frames.
- Undefined: fc logic is absent, and xi = xph, yi = yph.

## Structure
- Package vga_out_pkg holds:
  - the Bayer matrix constant (16 × 4-bit);
  - localparam VGA_OUT_LATENCY = 2;
  - 2-bit index and 4-bit threshold typedefs.
- Sub-module dither_q2: a purely combinational quantiser (v[7:0], T[3:0], en → q[1:0]), instantiated three times.
- Tracker and pipeline logic stay in the top module.

## Test plan
- Reset: hold reset 3 cycles with r_in = 0xFF and syncs = 1 → all outputs 0. On the 2nd cycle after release, outputs reflect the first post-reset inputs.
- Latency: a single-cycle pulse on hsync_in with r_in = 0x5A at cycle n → hsync = 1 and r = 0x5A exactly at cycle n+2.
- Dither pattern: constant r_in = 0x60 visible over 4×4 pixels, dither_en = 1. With v[5:2] = 8, rq = 2 where T < 8 and 1 elsewhere, e.g. row y0 = 2,1,2,1.
- Saturation and truncation:
  - r_in = 0xFF with dither_en = 1 → rq = 3 everywhere.
  - r_in = 0xBF with dither_en = 0 → rq = 2.
- Blanking: hblank_in = 1 with r_in = 0xFF → r = 0 and rq = 0 two cycles later; xph restarts at 0 on the next visible pixel.
- Temporal (macro defined): same 0x60 field over frames 0..4 → the frame-1 pattern differs from frame 0, and frame 4 equals frame 0.
